// File: rtl/cache_dre_pkg.sv
// Shared types and geometry helpers for the per-byte valid store.
package cache_dre_pkg;

  typedef enum logic {
    DRE_IDLE  = 1'b0,
    DRE_CLEAR = 1'b1
  } dre_state_t;

  function automatic int row_aw(input int addr_width, input int words_log2);
    return addr_width - words_log2;
  endfunction

  function automatic int row_bits(input int bytes, input int words_log2);
    return bytes << words_log2;
  endfunction

endpackage

// File: rtl/cache_dre_bank.sv
// Simple dual-port row RAM with per-way lane write enables; read-first, no reset.
module cache_dre_bank #(
  parameter int AW   = 8,
  parameter int W    = 8,
  parameter int WAYS = 4
) (
  input  logic                clk,
  input  logic [WAYS-1:0]     wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [WAYS*W-1:0]   wr_data,
  input  logic [AW-1:0]       rd_addr,
  output logic [WAYS*W-1:0]   rd_data
);

  logic [WAYS*W-1:0] mem [2**AW];
  logic [WAYS*W-1:0] rd_data_d;
  logic [WAYS*W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (wr_en[w]) mem[wr_addr][w*W +: W] <= wr_data[w*W +: W];
    end
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/cache_byte_valid_ram.sv
// Per-byte valid store: port mux, merge, forwarding, invalidate and clear sweep.
// Build option CACHE_DRE_AUTOCLR_EN: reset enters the clear sweep automatically.
module cache_byte_valid_ram
  import cache_dre_pkg::*;
#(
  parameter  int ADDR_WIDTH     = 9,
  parameter  int WAYS           = 4,
  parameter  int BYTES          = 4,
  parameter  int ROW_WORDS_LOG2 = 1,
  localparam int WAY_W          = $clog2(WAYS),
  localparam int ROW_AW         = row_aw(ADDR_WIDTH, ROW_WORDS_LOG2),
  localparam int ROW_BITS       = row_bits(BYTES, ROW_WORDS_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sel,
  input  logic [ADDR_WIDTH-1:0] rw_rd_addr,
  input  logic [WAY_W-1:0]      rw_rd_way,
  output logic [BYTES-1:0]      rw_rd_re,
  output logic                  rw_rd_full,
  input  logic [ADDR_WIDTH-1:0] rw_wr_addr,
  input  logic [WAY_W-1:0]      rw_wr_way,
  input  logic                  rw_wr_en,
  input  logic [BYTES-1:0]      rw_wr_re,
  input  logic [ADDR_WIDTH-1:0] ri_rd_addr,
  input  logic [WAY_W-1:0]      ri_rd_way,
  output logic [ROW_BITS-1:0]   ri_rd_data,
  input  logic [ADDR_WIDTH-1:0] ri_wr_addr,
  input  logic [WAY_W-1:0]      ri_wr_way,
  input  logic                  ri_wr_en,
  input  logic [ROW_BITS-1:0]   ri_wr_data,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic [WAY_W-1:0]      inv_way,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  wr_stall
);

`ifdef CACHE_DRE_AUTOCLR_EN
  localparam dre_state_t RST_STATE = DRE_CLEAR;
`else
  localparam dre_state_t RST_STATE = DRE_IDLE;
`endif

  dre_state_t state_q, state_d;
  logic [ROW_AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [WAY_W-1:0]          rd_way_q, rd_way_d;
  logic [ROW_WORDS_LOG2-1:0] rd_slot_q, rd_slot_d;
  logic                      fwd_q, fwd_d;
  logic [ROW_BITS-1:0]       fwd_data_q, fwd_data_d;
  logic                      rd_vld_q, rd_vld_d;

  logic [ADDR_WIDTH-1:0]     rd_addr;
  logic [WAY_W-1:0]          rd_way;
  logic                      port_we;
  logic [ADDR_WIDTH-1:0]     port_addr;
  logic [WAY_W-1:0]          port_way;
  logic [ROW_BITS-1:0]       port_data;
  logic [WAYS-1:0]           bank_we;
  logic [ROW_AW-1:0]         wr_row;
  logic [ROW_BITS-1:0]       wr_data;
  logic [WAYS*ROW_BITS-1:0]  bank_rd;
  logic [ROW_BITS-1:0]       rd_row_data;

  cache_dre_bank #(
    .AW   (ROW_AW),
    .W    (ROW_BITS),
    .WAYS (WAYS)
  ) u_bank (
    .clk     (clk),
    .wr_en   (bank_we),
    .wr_addr (wr_row),
    .wr_data ({WAYS{wr_data}}),
    .rd_addr (rd_addr[ADDR_WIDTH-1:ROW_WORDS_LOG2]),
    .rd_data (bank_rd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DRE_IDLE:  if (clr_req) state_d = DRE_CLEAR;
      DRE_CLEAR: if (clr_cnt_q == '1) state_d = DRE_IDLE;
      default:   state_d = DRE_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == DRE_CLEAR);
    clr_cnt_d = busy ? clr_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    rd_addr   = sel ? ri_rd_addr : rw_rd_addr;
    rd_way    = sel ? ri_rd_way  : rw_rd_way;
    port_we   = sel ? ri_wr_en   : rw_wr_en;
    port_addr = sel ? ri_wr_addr : rw_wr_addr;
    port_way  = sel ? ri_wr_way  : rw_wr_way;
    // Merge relies on ri_rd_data holding the row read at this address last cycle.
    port_data = sel ? ri_wr_data
                    : ri_rd_data | (ROW_BITS'(rw_wr_re)
                                    << (rw_wr_addr[ROW_WORDS_LOG2-1:0] * BYTES));
  end

  always_comb begin
    bank_we = '0;
    wr_row  = port_addr[ADDR_WIDTH-1:ROW_WORDS_LOG2];
    wr_data = port_data;
    if (busy) begin
      bank_we = '1;
      wr_row  = clr_cnt_q;
      wr_data = '0;
    end else if (inv_en) begin
      bank_we[inv_way] = 1'b1;
      wr_row  = inv_addr[ADDR_WIDTH-1:ROW_WORDS_LOG2];
      wr_data = '0;
    end else if (port_we) begin
      bank_we[port_way] = 1'b1;
    end
    wr_stall = busy | inv_en;
  end

  // The bank is read-first, so a same-cycle write to the read row/way is bypassed.
  always_comb begin
    rd_way_d   = rd_way;
    rd_slot_d  = rd_addr[ROW_WORDS_LOG2-1:0];
    fwd_d      = bank_we[rd_way] && (wr_row == rd_addr[ADDR_WIDTH-1:ROW_WORDS_LOG2]);
    fwd_data_d = wr_data;
    rd_vld_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q  <= '0;
      rd_way_q   <= '0;
      rd_slot_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      rd_vld_q   <= 1'b0;
    end else begin
      clr_cnt_q  <= clr_cnt_d;
      rd_way_q   <= rd_way_d;
      rd_slot_q  <= rd_slot_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      rd_vld_q   <= rd_vld_d;
    end
  end

  always_comb begin
    rd_row_data = fwd_q ? fwd_data_q : bank_rd[rd_way_q*ROW_BITS +: ROW_BITS];
    ri_rd_data  = (rd_vld_q && !busy) ? rd_row_data : '0;
    rw_rd_re    = ri_rd_data[rd_slot_q*BYTES +: BYTES];
    rw_rd_full  = &rw_rd_re;
  end

endmodule

// File: doc/cache_byte_valid_ram.md
# cache_byte_valid_ram

Per-byte valid-bit store for the data cache, covering every way and every word of each line. It is the parametrised successor of the fixed 4-way, 4-byte, 2-words-per-row byte-readable store. It adds:
- configurable way count, word width and row packing;
- a hardware clear sweep after reset or on request;
- single-row per-way invalidation;
- a whole-word "fully valid" flag.

It sits between the cache read/write control (rw) and refill/invalidate control (ri) paths, muxed by `sel`.

## Interface
- `ADDR_WIDTH`, 9: word address bits (row index plus word-in-row).
- `WAYS`, 4: number of ways (channels); `WAY_W = $clog2(WAYS)`.
- `BYTES`, 4: bytes per word, which is valid bits per word.
- `ROW_WORDS_LOG2`, 1: log2 of words packed per storage row. Derived: `ROW_AW = ADDR_WIDTH-ROW_WORDS_LOG2`, `ROW_BITS = BYTES<<ROW_WORDS_LOG2`.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sel` in 1: 0 selects the rw port, 1 selects the ri port (addresses, way, write).
- `rw_rd_addr` in ADDR_WIDTH; `rw_rd_way` in WAY_W: word read.
- `rw_rd_re` out BYTES: valid bits of the addressed word.
- `rw_rd_full` out 1: `&rw_rd_re`.
- `rw_wr_addr` in ADDR_WIDTH; `rw_wr_way` in WAY_W; `rw_wr_en` in 1; `rw_wr_re` in BYTES: bytes to mark valid.
- `ri_rd_addr` in ADDR_WIDTH; `ri_rd_way` in WAY_W.
- `ri_rd_data` out ROW_BITS: the whole row.
- `ri_wr_addr` in ADDR_WIDTH; `ri_wr_way` in WAY_W; `ri_wr_en` in 1; `ri_wr_data` in ROW_BITS: the whole row, overwritten.
- `inv_en` in 1; `inv_addr` in ADDR_WIDTH; `inv_way` in WAY_W: zero one row of one way.
- `clr_req` in 1: start a full clear sweep.
- `busy` out 1: clear sweep in progress.
- `wr_stall` out 1: port write this cycle is dropped (`busy | inv_en`).

## Operation
**Storage:** one simple dual-port RAM, `2**ROW_AW` rows × `WAYS*ROW_BITS`, with a per-way lane enable. Row address is `addr[ADDR_WIDTH-1:ROW_WORDS_LOG2]`; word slot is `addr[ROW_WORDS_LOG2-1:0]`.

**Reads:**
- Registered, 1-cycle latency.
- `ri_rd_data` is the selected way's row.
- `rw_rd_re` is that row's word slice, selected by the registered word slot.
- While `busy`, read outputs are forced to 0.

**rw write (merge):**
- Written row is `ri_rd_data | (rw_wr_re << slot*BYTES)`.
- Contract: the same address and way were presented as the read address on the previous cycle.
- Bits are only ever set, never cleared.

**ri write:** the row is replaced by `ri_wr_data`.

**Write-during-read forwarding:**
- Condition: the read row and way equal the write row and way, and a write is enabled in the same cycle.
- Result: the next-cycle read output is the written row, not the old RAM contents.

**Write-port priority:** sweep > invalidate > selected port write. A dropped port write is signalled by `wr_stall`, combinational in the same cycle.

**Invalidate:**
- Writes zeros to `inv_way` at row `inv_addr` in one cycle.
- Participates in forwarding as a write.

**FSM:**
- States: `DRE_IDLE`, `DRE_CLEAR`. Row counter `clr_cnt` is ROW_AW bits.
- `DRE_CLEAR`: writes zero to all ways at `clr_cnt` and increments each cycle. After the write to row `2**ROW_AW-1`, goes to `DRE_IDLE`; `clr_cnt` wraps to 0.
- `DRE_IDLE`: on `clr_req`, goes to `DRE_CLEAR` with `clr_cnt = 0`.
- `clr_req` during `DRE_CLEAR` is ignored; the sweep does not restart.
- `busy = (state == DRE_CLEAR)`.

## Timing
**Reset values:**
- `rw_rd_re`, `rw_rd_full`, `ri_rd_data`: 0.
- `clr_cnt`: 0.
- `busy`: 1 with `CACHE_DRE_AUTOCLR_EN` defined, else 0.
- `wr_stall` follows `busy`.

**Reset mid-sweep:** the sweep restarts from row 0.

**Sweep duration:**
- Exactly `2**ROW_AW` cycles, with `busy` high throughout.
- The first cycle with `busy = 0` after a sweep returns cleared data for any read issued in that cycle.

**Read latency:** 1 cycle on both ports. `sel` is sampled with the address; the output belongs to the port selected in the issue cycle.

## Configuration
`CACHE_DRE_AUTOCLR_EN`:
- Defined: the FSM resets into `DRE_CLEAR` and the store self-clears after every reset before accepting writes.
- Undefined: the FSM resets into `DRE_IDLE` and RAM contents are undefined until `clr_req` is issued.

## Structure
- `cache_dre_pkg` holds:
  - the `dre_state_t` enum (`DRE_IDLE`, `DRE_CLEAR`);
  - constant functions for `ROW_AW` and `ROW_BITS`.
- One sub-module, `cache_dre_bank`: simple dual-port RAM with `WAYS` lane enables of `ROW_BITS` each, read-first, no reset.
- Top level holds the port mux, merge, forwarding, invalidate priority and FSM.

## Test plan
All scenarios use default parameters: 256 rows, 8-bit rows.
- **Auto-clear:** `rst_n` low→high with `AUTOCLR_EN` -> `busy` = 1 for exactly 256 cycles; afterwards, read row 8'h7F way 3 -> `ri_rd_data` = 0.
- **Merge write:** `sel` = 0; read 9'h011 way 2, then write `rw_wr_re` = 4'b0011 -> re-read gives `rw_rd_re` = 4'b0011, `rw_rd_full` = 0. Repeat with 4'b1100 -> 4'b1111, `rw_rd_full` = 1; `ri_rd_data` = 8'hF0.
- **Forwarding:** `sel` = 1; write 8'hA5 and read the same row/way 9'h020/1 in the same cycle -> next cycle `ri_rd_data` = 8'hA5. Same cycle with read way 0 -> old way-0 data.
- **Invalidate collision:** `inv_en` with 9'h020 way 1, same cycle as `ri_wr_en` 8'h3C to the same row -> `wr_stall` = 1; later read returns 8'h00.
- **Sweep edge cases:** `clr_req` while idle -> 256-cycle sweep. `clr_req` at `clr_cnt` = 50 -> ignored, `busy` falls at the original end. `rst_n` pulsed at `clr_cnt` = 100 -> a full 256 cycles from reset release.
- **Port switching:** `sel` toggles each cycle with different addresses on each port -> each output matches its issue-cycle port; the unselected port's write has no effect.
